// File: rtl/std_divmod_pipe.sv
// std_divmod_pipe: iterative restoring divider returning quotient and remainder
// from a single operation, under a go/done latency-insensitive handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears all state
//   go            request; held high until done is observed
//   left          dividend, sampled on the start edge
//   right         divisor, sampled on the start edge
//   out_quotient  quotient of the last completed operation
//   out_remainder remainder of the last completed operation
//   done          completion, held while go stays high
//   div_by_zero   raised with done when the latched divisor was zero
module std_divmod_pipe #(
    parameter int unsigned width       = 32,
    parameter int unsigned signed_mode = 0,
    parameter int unsigned steps       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned n_iter = (steps == 0) ? 0 : width / steps;
    localparam int unsigned cnt_w  = (n_iter < 1) ? 1 : $clog2(n_iter + 1);
    localparam int unsigned rw     = width + 1;

    // Reject step counts that do not evenly divide the operand width.
    if (steps == 0 || n_iter * steps != width) begin : g_bad_steps
        $error("std_divmod_pipe: steps (%0d) must divide width (%0d)", steps, width);
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [width-1:0] dvd;      // dividend magnitude, becomes quotient as it shifts
    logic [width-1:0] dvs;      // divisor magnitude
    logic [rw-1:0]    rem;      // partial remainder
    logic             q_neg;
    logic             r_neg;
    logic [cnt_w-1:0] cnt;

    logic             left_neg;
    logic             right_neg;
    logic [width-1:0] left_mag;
    logic [width-1:0] right_mag;
    logic [width-1:0] dvd_nxt;
    logic [rw-1:0]    rem_nxt;
    logic [rw-1:0]    trial;

    // Operand magnitudes; the most-negative value maps onto 2^(width-1) unsigned.
    assign left_neg  = (signed_mode != 0) && left[width-1];
    assign right_neg = (signed_mode != 0) && right[width-1];
    assign left_mag  = left_neg  ? -left  : left;
    assign right_mag = right_neg ? -right : right;

    // One cycle's worth of chained restoring shift/compare/subtract stages.
    always_comb begin
        rem_nxt = rem;
        dvd_nxt = dvd;
        trial   = '0;
        for (int i = 0; i < int'(steps); i++) begin
            trial   = (rem_nxt << 1) | rw'(dvd_nxt[width-1]);
            dvd_nxt = dvd_nxt << 1;
            if (trial >= {1'b0, dvs}) begin
                trial      = trial - {1'b0, dvs};
                dvd_nxt[0] = 1'b1;
            end
            rem_nxt = trial;
        end
    end

    // Control FSM with registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            cnt           <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        dvd   <= left_mag;
                        dvs   <= right_mag;
                        rem   <= '0;
                        q_neg <= left_neg ^ right_neg;
                        r_neg <= left_neg;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!go) begin
                        state <= IDLE;
                    end else if (cnt == '0 && dvs == '0) begin
                        // dvd still holds |left|; re-applying the sign recovers left.
                        out_quotient  <= '1;
                        out_remainder <= r_neg ? -dvd : dvd;
                        div_by_zero   <= 1'b1;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (cnt == cnt_w'(n_iter)) begin
                        out_quotient  <= q_neg ? -dvd : dvd;
                        out_remainder <= r_neg ? -rem[width-1:0] : rem[width-1:0];
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        dvd <= dvd_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + cnt_w'(1);
                    end
                end
                DONE: begin
                    if (!go) begin
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_std_divmod_pipe.sv
// Directed bench for std_divmod_pipe across four 8-bit configurations:
// idx 0 unsigned/steps 1, idx 1 signed/steps 1, idx 2 unsigned/steps 4,
// idx 3 unsigned/steps 2.
module tb_std_divmod_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       go  [4];
    logic [7:0] lft [4];
    logic [7:0] rgt [4];
    logic [7:0] q   [4];
    logic [7:0] rm  [4];
    logic       dn  [4];
    logic       dz  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    std_divmod_pipe #(.width(8), .signed_mode(0), .steps(1)) u_u1 (
        .clk(clk), .reset(reset), .go(go[0]), .left(lft[0]), .right(rgt[0]),
        .out_quotient(q[0]), .out_remainder(rm[0]), .done(dn[0]), .div_by_zero(dz[0]));
    std_divmod_pipe #(.width(8), .signed_mode(1), .steps(1)) u_s1 (
        .clk(clk), .reset(reset), .go(go[1]), .left(lft[1]), .right(rgt[1]),
        .out_quotient(q[1]), .out_remainder(rm[1]), .done(dn[1]), .div_by_zero(dz[1]));
    std_divmod_pipe #(.width(8), .signed_mode(0), .steps(4)) u_u4 (
        .clk(clk), .reset(reset), .go(go[2]), .left(lft[2]), .right(rgt[2]),
        .out_quotient(q[2]), .out_remainder(rm[2]), .done(dn[2]), .div_by_zero(dz[2]));
    std_divmod_pipe #(.width(8), .signed_mode(0), .steps(2)) u_u2 (
        .clk(clk), .reset(reset), .go(go[3]), .left(lft[3]), .right(rgt[3]),
        .out_quotient(q[3]), .out_remainder(rm[3]), .done(dn[3]), .div_by_zero(dz[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start an operation, measure edges from start to done, check results,
    // and confirm done holds while go stays high. Operands are scrambled
    // right after the start edge to show they are not re-sampled.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input int lat_exp, input logic [7:0] qe, input logic [7:0] re,
                          input logic dze, input string tag);
        int lat;
        @(negedge clk);
        go[idx]  = 1'b1;
        lft[idx] = a;
        rgt[idx] = b;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                lft[idx] = ~a;
                rgt[idx] = 8'h03;
            end
        end while (!dn[idx] && lat < 40);
        check({tag, " latency"}, 32'(lat - 1), 32'(lat_exp));
        check({tag, " quotient"}, 32'(q[idx]), 32'(qe));
        check({tag, " remainder"}, 32'(rm[idx]), 32'(re));
        check({tag, " div_by_zero"}, 32'(dz[idx]), 32'(dze));
        repeat (2) @(negedge clk);
        check({tag, " done held"}, 32'(dn[idx]), 32'd1);
    endtask

    // Drop go; one edge later done/flag are low and results are held.
    task automatic drop_go(input int idx, input logic [7:0] qe, input logic [7:0] re,
                           input string tag);
        @(negedge clk);
        go[idx] = 1'b0;
        @(negedge clk);
        check({tag, " done drop"}, 32'(dn[idx]), 32'd0);
        check({tag, " flag drop"}, 32'(dz[idx]), 32'd0);
        check({tag, " quotient hold"}, 32'(q[idx]), 32'(qe));
        check({tag, " remainder hold"}, 32'(rm[idx]), 32'(re));
    endtask

    initial begin
        int hits;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go[i]  = 1'b0;
            lft[i] = '0;
            rgt[i] = '0;
        end
        #12;
        for (int i = 0; i < 4; i++)
            check($sformatf("reset state %0d", i), 32'({q[i], rm[i], dn[i], dz[i]}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, 8'd200, 8'd7, 9, 8'd28, 8'd4, 1'b0, "u 200/7");
        drop_go(0, 8'd28, 8'd4, "u 200/7");

        run_op(1, 8'hF9, 8'h02, 9, 8'hFD, 8'hFF, 1'b0, "s -7/2");
        drop_go(1, 8'hFD, 8'hFF, "s -7/2");
        run_op(1, 8'h07, 8'hFE, 9, 8'hFD, 8'h01, 1'b0, "s 7/-2");
        drop_go(1, 8'hFD, 8'h01, "s 7/-2");
        run_op(1, 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0, "s min/-1");
        drop_go(1, 8'h80, 8'h00, "s min/-1");

        run_op(2, 8'd255, 8'd16, 3, 8'd15, 8'd15, 1'b0, "u4 255/16");
        drop_go(2, 8'd15, 8'd15, "u4 255/16");
        run_op(3, 8'd255, 8'd16, 5, 8'd15, 8'd15, 1'b0, "u2 255/16");
        drop_go(3, 8'd15, 8'd15, "u2 255/16");

        run_op(1, 8'hF3, 8'h00, 1, 8'hFF, 8'hF3, 1'b1, "s div0");
        drop_go(1, 8'hFF, 8'hF3, "s div0");

        // Abort three edges into a calculation.
        @(negedge clk);
        go[0]  = 1'b1;
        lft[0] = 8'd200;
        rgt[0] = 8'd7;
        repeat (4) @(negedge clk);
        go[0] = 1'b0;
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0]) hits++;
        end
        check("abort done", 32'(hits), 32'd0);
        check("abort quotient hold", 32'(q[0]), 32'd28);
        check("abort remainder hold", 32'(rm[0]), 32'd4);

        // Fresh op after abort; holding go high afterwards must not restart.
        run_op(0, 8'd100, 8'd9, 9, 8'd11, 8'd1, 1'b0, "u 100/9");
        lft[0] = 8'd50;
        rgt[0] = 8'd5;
        repeat (15) @(negedge clk);
        check("no restart done", 32'(dn[0]), 32'd1);
        check("no restart quotient", 32'(q[0]), 32'd11);
        check("no restart remainder", 32'(rm[0]), 32'd1);
        drop_go(0, 8'd11, 8'd1, "u 100/9");

        // Asynchronous reset between edges mid-calculation.
        @(negedge clk);
        go[0]  = 1'b1;
        lft[0] = 8'd200;
        rgt[0] = 8'd7;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async reset quotient", 32'(q[0]), 32'd0);
        check("async reset remainder", 32'(rm[0]), 32'd0);
        check("async reset other quotient", 32'(q[1]), 32'd0);
        check("async reset other remainder", 32'(rm[1]), 32'd0);
        go[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 8'd50, 8'd5, 9, 8'd10, 8'd0, 1'b0, "u 50/5");
        drop_go(0, 8'd10, 8'd0, "u 50/5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
